prbs_checker: RTL and testbench

//  Parametrised, multi-bit-per-cycle PRBS checker for any Fibonacci LFSR polynomial in the team's polynomial format.
//  - Polynomial is DEG bits wide, x^0 implied; bit i set = tap at stage i+1.
//  - Self-synchronises to an incoming stream, declares lock and counts bit errors.
//  - Drops lock on sustained corruption and re-hunts.
//  - Sits behind SERDES/loopback paths for link BER testing.

---
 rtl/prbs_checker.sv | 161 ++++++++++++++++
 tb/tb_prbs_checker.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Self-synchronising multi-bit PRBS checker for a Fibonacci LFSR stream.
// Ports: aclk/aresetn, AXI-S sink (tvalid/tdata/tready), err_clear, locked, err_valid/err_bits, err_cnt.
module prbs_checker #(
    parameter int             DEG        = 7,
    parameter logic [DEG-1:0] POLY       = 7'b1100000,
    parameter int             DATA_W     = 8,
    parameter int             INVERT     = 0,
    parameter int             LOCK_BEATS = 4,
    parameter int             LOSS_BEATS = 4,
    parameter int             CNT_W      = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_axis_tvalid,
    input  logic [DATA_W-1:0] s_axis_tdata,
    output logic              s_axis_tready,
    input  logic              err_clear,
    output logic              locked,
    output logic              err_valid,
    output logic [DATA_W-1:0] err_bits,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int   HUNT_BEATS = (DEG + DATA_W - 1) / DATA_W;
    localparam int   PC_W       = $clog2(DATA_W + 1);
    localparam int   SUM_W      = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam int   BC_W       = 16;
    localparam logic INV        = (INVERT != 0);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DEG-1:0]    lfsr;
    logic [DEG-1:0]    lfsr_nxt;
    logic [DEG-1:0]    s;
    logic [DATA_W-1:0] mask;
    logic              r;
    logic              e;
    logic [BC_W-1:0]   bcnt;
    logic [BC_W-1:0]   bcnt_nxt;
    logic [BC_W-1:0]   bcnt_inc;
    logic [PC_W-1:0]   pc;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              beat_locked;

    assign beat_locked = s_axis_tvalid && (state == LOCKED);
    assign locked      = (state == LOCKED);
    assign bcnt_inc    = bcnt + BC_W'(1);

    // Bit-serial LFSR step unrolled across the beat. Outside LOCKED the
    // received bit is fed back (self-sync); in LOCKED the prediction is
    // fed back so one wrong bit does not spawn further errors.
    always_comb begin
        s    = lfsr;
        mask = '0;
        r    = 1'b0;
        e    = 1'b0;
        for (int k = 0; k < DATA_W; k++) begin
            r       = s_axis_tdata[k] ^ INV;
            e       = ^(s & POLY);
            mask[k] = r ^ e;
            s       = {s[DEG-2:0], (state == LOCKED) ? e : r};
        end
        lfsr_nxt = s;
    end

    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        if (s_axis_tvalid) begin
            unique case (state)
                HUNT: begin
                    if (bcnt_inc >= BC_W'(HUNT_BEATS)) begin
                        state_nxt = VERIFY;
                        bcnt_nxt  = '0;
                    end else begin
                        bcnt_nxt = bcnt_inc;
                    end
                end
                VERIFY: begin
                    // An all-zero register would "predict" an all-zero
                    // stream perfectly, so it never counts as good.
                    if (mask == '0 && lfsr_nxt != '0) begin
                        if (bcnt_inc == BC_W'(LOCK_BEATS)) begin
                            state_nxt = LOCKED;
                            bcnt_nxt  = '0;
                        end else begin
                            bcnt_nxt = bcnt_inc;
                        end
                    end else begin
                        bcnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (mask != '0) begin
                        if (bcnt_inc == BC_W'(LOSS_BEATS)) begin
                            state_nxt = HUNT;
                            bcnt_nxt  = '0;
                        end else begin
                            bcnt_nxt = bcnt_inc;
                        end
                    end else begin
                        bcnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    bcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Clear takes effect before the current beat's errors are added.
    always_comb begin
        pc = '0;
        for (int k = 0; k < DATA_W; k++) begin
            pc = pc + PC_W'(mask[k]);
        end
        sum = (err_clear ? '0 : SUM_W'(err_cnt))
            + SUM_W'(beat_locked ? pc : '0);
        if (sum > SUM_W'({CNT_W{1'b1}})) begin
            cnt_nxt = '1;
        end else begin
            cnt_nxt = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= HUNT;
            lfsr  <= '0;
            bcnt  <= '0;
        end else if (s_axis_tvalid) begin
            state <= state_nxt;
            lfsr  <= lfsr_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axis_tready <= 1'b0;
            err_valid     <= 1'b0;
            err_bits      <= '0;
            err_cnt       <= '0;
        end else begin
            s_axis_tready <= 1'b1;
            err_valid     <= beat_locked;
            err_bits      <= beat_locked ? mask : '0;
            err_cnt       <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: default, inverted-stream and 4-bit-counter
// instances share one stimulus stream and one queue-based reference model.
module tb_prbs_checker;

    localparam int             DEG  = 7;
    localparam int             DW   = 8;
    localparam logic [DEG-1:0] POLY = 7'b1100000;
    localparam int             HB   = (DEG + DW - 1) / DW;

    typedef struct packed {
        logic        tready;
        logic        locked;
        logic        err_valid;
        logic [7:0]  err_bits;
        logic [31:0] err_cnt;
        logic [3:0]  err_cnt4;
    } exp_t;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       tvalid = 1'b0;
    logic [7:0] tdata = '0;
    logic [7:0] tdata_n;
    logic       err_clear = 1'b0;

    logic        m_tready, m_locked, m_ev;
    logic [7:0]  m_eb;
    logic [31:0] m_cnt;
    logic        i_tready, i_locked, i_ev;
    logic [7:0]  i_eb;
    logic [31:0] i_cnt;
    logic        s_tready, s_locked, s_ev;
    logic [7:0]  s_eb;
    logic [3:0]  s_cnt;

    int total = 0;
    int bad = 0;

    exp_t sb[$];
    exp_t mon_x;

    bit   g[$];
    bit   m_h[$];
    int   m_st;
    int   m_bc;
    longint err64;
    longint err4;

    assign tdata_n = ~tdata;

    always #5 aclk = ~aclk;

    prbs_checker u_main (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
        .s_axis_tready(m_tready), .err_clear(err_clear),
        .locked(m_locked), .err_valid(m_ev),
        .err_bits(m_eb), .err_cnt(m_cnt)
    );

    prbs_checker #(.INVERT(1)) u_inv (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(tvalid), .s_axis_tdata(tdata_n),
        .s_axis_tready(i_tready), .err_clear(err_clear),
        .locked(i_locked), .err_valid(i_ev),
        .err_bits(i_eb), .err_cnt(i_cnt)
    );

    prbs_checker #(.CNT_W(4)) u_sat (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
        .s_axis_tready(s_tready), .err_clear(err_clear),
        .locked(s_locked), .err_valid(s_ev),
        .err_bits(s_eb), .err_cnt(s_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h want %0h at %0t",
                         name, act, want, $time);
        end
    endtask

    // Reference PRBS7 source: x[n] = x[n-7] ^ x[n-6], seeded all ones.
    function automatic logic [7:0] prbs_byte();
        logic [7:0] b;
        bit nb;
        b = '0;
        for (int k = 0; k < DW; k++) begin
            nb = g[0] ^ g[1];
            g.push_back(nb);
            void'(g.pop_front());
            b[k] = nb;
        end
        return b;
    endfunction

    function automatic void model_reset();
        exp_t x;
        m_st = 0;
        m_bc = 0;
        m_h.delete();
        for (int i = 0; i < DEG; i++) m_h.push_back(1'b0);
        err64 = 0;
        err4 = 0;
        x = '0;
        sb.push_back(x);
    endfunction

    // Behavioural checker: history queue holds the last DEG bits the
    // checker believes; prediction is XOR of tapped ages.
    function automatic void model_step(input logic v, input logic [7:0] d,
                                       input logic clr);
        exp_t x;
        logic [7:0] mask;
        bit e;
        bit nz;
        int was;
        int n;
        x = '0;
        mask = '0;
        if (clr) begin
            err64 = 0;
            err4 = 0;
        end
        if (v) begin
            was = m_st;
            for (int k = 0; k < DW; k++) begin
                e = 1'b0;
                for (int i = 0; i < DEG; i++)
                    if (POLY[i]) e = e ^ m_h[DEG-1-i];
                mask[k] = d[k] ^ e;
                m_h.push_back((was == 2) ? e : d[k]);
                void'(m_h.pop_front());
            end
            nz = 1'b0;
            foreach (m_h[i]) if (m_h[i]) nz = 1'b1;
            if (was == 2) begin
                n = $countones(mask);
                x.err_valid = 1'b1;
                x.err_bits = mask;
                err64 = err64 + n;
                if (err64 > 64'hFFFF_FFFF) err64 = 64'hFFFF_FFFF;
                err4 = err4 + n;
                if (err4 > 15) err4 = 15;
            end
            if (was == 0) begin
                m_bc++;
                if (m_bc >= HB) begin m_st = 1; m_bc = 0; end
            end else if (was == 1) begin
                if (mask == 0 && nz) begin
                    m_bc++;
                    if (m_bc == 4) begin m_st = 2; m_bc = 0; end
                end else m_bc = 0;
            end else begin
                if (mask != 0) begin
                    m_bc++;
                    if (m_bc == 4) begin m_st = 0; m_bc = 0; end
                end else m_bc = 0;
            end
        end
        x.tready = 1'b1;
        x.locked = (m_st == 2);
        x.err_cnt = 32'(err64);
        x.err_cnt4 = 4'(err4);
        sb.push_back(x);
    endfunction

    task automatic cycle(input logic v, input logic [7:0] d, input logic clr);
        @(negedge aclk);
        aresetn = 1'b1;
        tvalid = v;
        tdata = d;
        err_clear = clr;
        model_step(v, d, clr);
    endtask

    task automatic reset_cycle();
        @(negedge aclk);
        aresetn = 1'b0;
        tvalid = 1'b0;
        err_clear = 1'b0;
        model_reset();
    endtask

    task automatic settle();
        @(posedge aclk);
        #2;
    endtask

    task automatic send(input int n, input logic [7:0] flip, input int gap);
        int sent;
        sent = 0;
        while (sent < n) begin
            if (gap > 0 && $urandom_range(0, 99) < gap) begin
                cycle(1'b0, 8'($urandom), 1'b0);
            end else begin
                cycle(1'b1, prbs_byte() ^ flip, 1'b0);
                sent++;
            end
        end
    endtask

    always begin
        @(posedge aclk);
        #1;
        if (sb.size() != 0) begin
            mon_x = sb.pop_front();
            chk("main", 64'({m_tready, m_locked, m_ev, m_eb, m_cnt}),
                64'({mon_x.tready, mon_x.locked, mon_x.err_valid,
                     mon_x.err_bits, mon_x.err_cnt}));
            chk("inv", 64'({i_tready, i_locked, i_ev, i_eb, i_cnt}),
                64'({mon_x.tready, mon_x.locked, mon_x.err_valid,
                     mon_x.err_bits, mon_x.err_cnt}));
            chk("sat4", 64'({s_tready, s_locked, s_ev, s_eb, s_cnt}),
                64'({mon_x.tready, mon_x.locked, mon_x.err_valid,
                     mon_x.err_bits, mon_x.err_cnt4}));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int rr;
        logic clr;
        for (int i = 0; i < DEG; i++) g.push_back(1'b1);

        repeat (3) reset_cycle();
        settle();
        chk("rst_locked", 64'(m_locked), 64'd0);
        chk("rst_tready", 64'(m_tready), 64'd0);

        // clean stream: lock exactly on the 5th valid beat
        send(4, 8'h00, 0);
        settle();
        chk("lock_4th", 64'(m_locked), 64'd0);
        send(1, 8'h00, 0);
        settle();
        chk("lock_5th", 64'(m_locked), 64'd1);
        chk("inv_lock", 64'(i_locked), 64'd1);
        send(1995, 8'h00, 30);
        settle();
        chk("clean_locked", 64'(m_locked), 64'd1);
        chk("clean_cnt", 64'(m_cnt), 64'd0);

        // single bit error
        send(1, 8'h08, 0);
        settle();
        chk("flip_bits", 64'(m_eb), 64'h08);
        chk("flip_valid", 64'(m_ev), 64'd1);
        chk("flip_cnt", 64'(m_cnt), 64'd1);
        send(3, 8'h00, 0);
        settle();
        chk("after_bits", 64'(m_eb), 64'd0);
        chk("after_locked", 64'(m_locked), 64'd1);

        // reset mid-stream, then relock
        reset_cycle();
        settle();
        chk("mid_locked", 64'(m_locked), 64'd0);
        chk("mid_cnt", 64'(m_cnt), 64'd0);
        chk("mid_tready", 64'(m_tready), 64'd0);
        send(4, 8'h00, 0);
        settle();
        chk("relock_4th", 64'(m_locked), 64'd0);
        send(1, 8'h00, 0);
        settle();
        chk("relock_5th", 64'(m_locked), 64'd1);

        // four inverted beats drop lock
        send(3, 8'h00, 0);
        send(3, 8'hFF, 0);
        settle();
        chk("loss_3rd", 64'(m_locked), 64'd1);
        send(1, 8'hFF, 0);
        settle();
        chk("loss_4th", 64'(m_locked), 64'd0);
        chk("loss_cnt", 64'(m_cnt), 64'd32);
        send(4, 8'h00, 0);
        settle();
        chk("reacq_4th", 64'(m_locked), 64'd0);
        send(1, 8'h00, 0);
        settle();
        chk("reacq_5th", 64'(m_locked), 64'd1);
        chk("reacq_cnt", 64'(m_cnt), 64'd32);

        // saturation on the 4-bit counter
        cycle(1'b0, 8'h00, 1'b1);
        settle();
        chk("clr_main", 64'(m_cnt), 64'd0);
        chk("clr_sat", 64'(s_cnt), 64'd0);
        for (int i = 0; i < 20; i++) begin
            send(1, 8'(1 << $urandom_range(0, 7)), 0);
            send(1, 8'h00, 0);
        end
        settle();
        chk("sat_cnt", 64'(s_cnt), 64'd15);
        chk("sat_main", 64'(m_cnt), 64'd20);
        cycle(1'b1, prbs_byte() ^ 8'h12, 1'b1);
        settle();
        chk("clr_err_main", 64'(m_cnt), 64'd2);
        chk("clr_err_sat", 64'(s_cnt), 64'd2);
        cycle(1'b0, 8'h00, 1'b1);
        settle();
        chk("clr_only", 64'(s_cnt), 64'd0);

        // degenerate all-zero stream (all-ones on the inverted instance)
        reset_cycle();
        for (int i = 0; i < 100; i++) cycle(1'b1, 8'h00, 1'b0);
        settle();
        chk("zero_main", 64'(m_locked), 64'd0);
        chk("zero_inv", 64'(i_locked), 64'd0);
        send(5, 8'h00, 0);
        settle();
        chk("inv_relock", 64'(i_locked), 64'd1);
        chk("inv_cnt", 64'(i_cnt), 64'd0);

        // randomized errors, bursts, gaps and clears
        repeat (1500) begin
            rr = $urandom_range(0, 99);
            clr = ($urandom_range(0, 49) == 0);
            if (rr < 20) begin
                cycle(1'b0, 8'($urandom), clr);
            end else begin
                d = prbs_byte();
                if (rr < 30) d = d ^ 8'(1 << $urandom_range(0, 7));
                else if (rr < 34) d = ~d;
                cycle(1'b1, d, clr);
            end
        end
        settle();
        settle();
        chk("drain", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
